// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free PR indices with speculative head,
// retire head and tail. Define FREE_LIST_BYPASS_EN to forward a retiring PR to rename when the list is empty.
module free_list #(
  parameter int PHYS_REG_SZ     = 64,
  parameter int PHYS_REG_IDX_SZ = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_req,
  output logic                       alloc_valid,
  output logic [PHYS_REG_IDX_SZ:0]   alloc_pr,
  input  logic                       retire_enable,
  input  logic                       retire_has_dest,
  input  logic [PHYS_REG_IDX_SZ:0]   retire_old_pr,
  input  logic                       restore_enable,
  output logic [PHYS_REG_IDX_SZ+1:0] free_count,
  output logic                       empty
);

  localparam int IDX_W = PHYS_REG_IDX_SZ + 1;
  localparam int CNT_W = PHYS_REG_IDX_SZ + 2;
  localparam int DEPTH = PHYS_REG_SZ - 1;

  typedef logic [IDX_W-1:0] pr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam pr_t  LAST_PTR = pr_t'(DEPTH - 1);
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  pr_t  buf_q [DEPTH];
  pr_t  buf_d [DEPTH];
  pr_t  spec_head_q, spec_head_d;
  pr_t  retire_head_q, retire_head_d;
  pr_t  tail_q, tail_d;
  cnt_t count_q, count_d;
  // Distance tail - retire head, held as a count so a completely free list is not read as zero.
  cnt_t commit_count_q, commit_count_d;

  logic retire_dest;
  logic push_req;
  logic push;
  logic pop;
  logic bypass;
  logic overflow;

  function automatic pr_t ptr_inc(input pr_t p);
    return (p == LAST_PTR) ? '0 : p + pr_t'(1);
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    retire_dest = retire_enable && retire_has_dest;
    push_req    = retire_dest && (retire_old_pr != '0);
    empty       = (count_q == '0);
`ifdef FREE_LIST_BYPASS_EN
    bypass      = empty && push_req;
`else
    bypass      = 1'b0;
`endif
    alloc_valid = !empty || bypass;
    alloc_pr    = bypass ? retire_old_pr : buf_q[spec_head_q];
    free_count  = count_q;
    pop         = alloc_req && alloc_valid && !restore_enable;
    overflow    = push_req && (count_q == FULL_CNT) && !pop;
    push        = push_req && !overflow;

    buf_d          = buf_q;
    spec_head_d    = spec_head_q;
    retire_head_d  = retire_head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_count_d = commit_count_q;

    if (push) begin
      buf_d[tail_q] = retire_old_pr;
      tail_d        = ptr_inc(tail_q);
    end
    if (retire_dest) begin
      retire_head_d = ptr_inc(retire_head_q);
    end
    commit_count_d = commit_count_q - cnt_t'(retire_dest) + cnt_t'(push);

    // Retire has already updated retire head and tail; restore rewinds to that state.
    if (restore_enable) begin
      spec_head_d = retire_head_d;
      count_d     = commit_count_d;
    end else begin
      if (pop) begin
        spec_head_d = ptr_inc(spec_head_q);
      end
      count_d = count_q - cnt_t'(pop) + cnt_t'(push);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the buffer is reset because its contents at reset are the initial free list, not don't-care data.
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= pr_t'(i + 1);
      end
      spec_head_q    <= '0;
      retire_head_q  <= '0;
      tail_q         <= '0;
      count_q        <= FULL_CNT;
      commit_count_q <= FULL_CNT;
    end else begin
      buf_q          <= buf_d;
      spec_head_q    <= spec_head_d;
      retire_head_q  <= retire_head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_count_q <= commit_count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow);

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue-level model predicts each cycle's outputs and
// a negedge monitor compares them; directed scenarios add fixed-value checks.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_pr;
  logic       retire_enable;
  logic       retire_has_dest;
  logic [5:0] retire_old_pr;
  logic       restore_enable;
  logic [6:0] free_count;
  logic       empty;

  free_list dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_pr        (alloc_pr),
    .retire_enable   (retire_enable),
    .retire_has_dest (retire_has_dest),
    .retire_old_pr   (retire_old_pr),
    .restore_enable  (restore_enable),
    .free_count      (free_count),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [5:0] pr;
    int         count;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] spec_fl[$];    // free PRs as rename sees them
  logic [5:0] commit_fl[$];  // free PRs as retirement sees them (includes in-flight allocations)

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
  endtask

  task automatic model_init();
    spec_fl.delete();
    commit_fl.delete();
    for (int i = 1; i <= 63; i++) begin
      spec_fl.push_back(6'(i));
      commit_fl.push_back(6'(i));
    end
    exp_q.delete();
  endtask

  // Drive one cycle's inputs, queue the expected outputs, then advance the model past the edge.
  task automatic set_in(input logic a, input logic re, input logic hd,
                        input logic [5:0] old, input logic rs);
    exp_t e;
    logic push_req, bypass, pop;
    alloc_req       = a;
    retire_enable   = re;
    retire_has_dest = hd;
    retire_old_pr   = old;
    restore_enable  = rs;
    push_req = re && hd && (old != 6'd0);
    bypass   = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    bypass   = (spec_fl.size() == 0) && push_req;
`endif
    e.valid = (spec_fl.size() != 0) || bypass;
    e.pr    = (spec_fl.size() != 0) ? spec_fl[0] : old;
    e.count = spec_fl.size();
    exp_q.push_back(e);
    pop = a && e.valid && !rs;
    if (re && hd) begin
      void'(commit_fl.pop_front());
      if (old != 6'd0) begin
        commit_fl.push_back(old);
        spec_fl.push_back(old);
      end
    end
    if (rs) spec_fl = commit_fl;
    else if (pop) void'(spec_fl.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic a, input logic re, input logic hd,
                      input logic [5:0] old, input logic rs);
    set_in(a, re, hd, old, rs);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alloc_req = 1'b0; retire_enable = 1'b0; retire_has_dest = 1'b0;
    retire_old_pr = 6'd0; restore_enable = 1'b0;
    model_init();
    tick();
    reset = 1'b0;
  endtask

  task automatic allocs(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mon_free_count", int'(free_count), e.count);
      check("mon_empty", int'(empty), int'(e.count == 0));
      check("mon_alloc_valid", int'(alloc_valid), int'(e.valid));
      if (e.valid) check("mon_alloc_pr", int'(alloc_pr), int'(e.pr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int inflight;
    logic a, re, hd, rs;
    logic [5:0] old;

    reset = 1'b1;
    alloc_req = 1'b0; retire_enable = 1'b0; retire_has_dest = 1'b0;
    retire_old_pr = 6'd0; restore_enable = 1'b0;
    model_init();
    #1;
    check("reset_free_count", int'(free_count), 63);
    check("reset_alloc_valid", int'(alloc_valid), 1);
    check("reset_alloc_pr", int'(alloc_pr), 1);
    check("reset_empty", int'(empty), 0);
    tick();
    reset = 1'b0;

    // Three allocations hand out PR1..3
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      #1 check("seq_alloc_pr", int'(alloc_pr), k);
      tick();
      check("seq_free_count", int'(free_count), 63 - k);
    end

    // Drain to empty, then an extra request must change nothing
    allocs(60);
    check("drain_empty", int'(empty), 1);
    check("drain_alloc_valid", int'(alloc_valid), 0);
    check("drain_free_count", int'(free_count), 0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    check("extra_alloc_count", int'(free_count), 0);
    step(1'b0, 1'b1, 1'b1, 6'd5, 1'b0);
    check("after_extra_pr", int'(alloc_pr), 5);
    check("after_extra_count", int'(free_count), 1);

    // Alloc 5, retire 2 without an old mapping, restore
    do_reset();
    allocs(5);
    step(1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    check("restore_alloc_pr", int'(alloc_pr), 3);
    check("restore_free_count", int'(free_count), 61);

    // Retire old PR7 alongside an allocation; PR7 comes back after wrap
    do_reset();
    allocs(4);
    step(1'b1, 1'b1, 1'b1, 6'd7, 1'b0);
    check("push_pop_count", int'(free_count), 59);
    allocs(58);
    check("wrap_fifo_pr7", int'(alloc_pr), 7);

    // Restore + retire(9) + alloc together
    do_reset();
    allocs(3);
    step(1'b1, 1'b1, 1'b1, 6'd9, 1'b1);
    check("rrr_free_count", int'(free_count), 63);
    check("rrr_alloc_pr", int'(alloc_pr), 2);
    allocs(62);
    check("rrr_pr9_present", int'(alloc_pr), 9);

    // Empty list with a retiring PR12
    do_reset();
    allocs(63);
    set_in(1'b1, 1'b1, 1'b1, 6'd12, 1'b0);
    #1;
`ifdef FREE_LIST_BYPASS_EN
    check("bypass_valid", int'(alloc_valid), 1);
    check("bypass_pr", int'(alloc_pr), 12);
    tick();
    check("bypass_count", int'(free_count), 0);
`else
    check("nobypass_valid", int'(alloc_valid), 0);
    tick();
    check("nobypass_count", int'(free_count), 1);
    check("nobypass_pr", int'(alloc_pr), 12);
`endif

    // Randomized traffic, with an asynchronous reset dropped in mid-run
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("midreset_free_count", int'(free_count), 63);
        check("midreset_alloc_pr", int'(alloc_pr), 1);
        check("midreset_alloc_valid", int'(alloc_valid), 1);
        check("midreset_empty", int'(empty), 0);
        model_init();
        #1 reset = 1'b0;
      end
      inflight = commit_fl.size() - spec_fl.size();
      a   = ($urandom_range(99) < 60);
      re  = ($urandom_range(99) < 50);
      hd  = (inflight > 0) ? ($urandom_range(99) < 80) : 1'b0;
      old = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
      rs  = ($urandom_range(99) < 3);
      step(a, re, hd, old, rs);
    end

    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
